// File: rtl/pp_column_gen.sv
// -----------------------------------------------------------------------------
// pp_column_gen
//
// Sequential partial-product generator feeding the column-compressor stage of
// the approximate multiplier. One N x N unsigned operand pair is accepted per
// transaction. The AND-array partial products pp[i][j] = a[j] & b[i] are then
// streamed one weight column (k = i + j) per beat, lowest weight first. The
// exact product a*b rides along on the final beat as a golden reference.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept an operand pair (registered-state decode)
//   a, b       in   N-bit multiplicand / multiplier
//   out_valid  out  column beat valid (registered-state decode)
//   out_ready  in   downstream accepts the current beat
//   col_bits   out  packed partial-product bits of column col_idx; bit p holds
//                   pp[lo+p][k-lo-p], lo = max(0, k-N+1); unused bits are 0
//   col_cnt    out  column height (number of valid bits in col_bits)
//   col_idx    out  column weight k
//   out_last   out  final column beat (k = COLS-1)
//   prod       out  exact product, nonzero only on the last beat
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. The producer holds valid and all payload stable until that edge;
// ready never depends combinationally on valid, and valid/ready outputs are
// decoded from registered state only.
//
// COLS and CW are derived from N and must not be overridden.
// -----------------------------------------------------------------------------
module pp_column_gen #(
   parameter int N    = 6,
   parameter int COLS = 2*N-1,
   parameter int CW   = $clog2(2*N-1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    col_bits,
   output logic [3:0]      col_cnt,
   output logic [CW-1:0]   col_idx,
   output logic            out_last,
   output logic [2*N-1:0]  prod
);

   localparam int PW = 2*N;
   localparam logic [CW-1:0] K_LAST = CW'(COLS-1);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   state_t          state_q,    state_d;
   logic [N-1:0]    a_q,        a_d;
   logic [N-1:0]    b_q,        b_d;
   logic [CW-1:0]   k_q,        k_d;
   logic [PW-1:0]   acc_q,      acc_d;
   logic [N-1:0]    col_bits_q, col_bits_d;
   logic [3:0]      col_cnt_q,  col_cnt_d;
   logic            out_last_q, out_last_d;
   logic [PW-1:0]   prod_q,     prod_d;

   // ---------------------------------------------------------------------------
   // Column table
   //
   // Every column of the AND array is built from one operand source. In IDLE
   // the source is the live input pair so that column 0 can be registered on
   // the acceptance edge; in STREAM it is the captured pair, which makes the
   // stream immune to a and b changing after acceptance.
   // ---------------------------------------------------------------------------
   logic [N-1:0] src_a;
   logic [N-1:0] src_b;
   logic [N-1:0] col_tab [COLS];
   logic [3:0]   cnt_tab [COLS];

   assign src_a = (state_q == IDLE) ? a : a_q;
   assign src_b = (state_q == IDLE) ? b : b_q;

   for (genvar kk = 0; kk < COLS; kk++) begin : g_col
      // Rows that contribute to column kk run from LO to HI.
      localparam int LO = (kk > N-1) ? (kk - N + 1) : 0;
      localparam int HI = (kk < N-1) ? kk : (N - 1);

      for (genvar p = 0; p < N; p++) begin : g_bit
         if (p <= HI - LO) begin : g_used
            // Row i = LO + p, column-of-a j = kk - i.
            assign col_tab[kk][p] = src_b[LO + p] & src_a[kk - LO - p];
         end else begin : g_pad
            assign col_tab[kk][p] = 1'b0;
         end
      end

      assign cnt_tab[kk] = 4'(HI - LO + 1);
   end

   // ---------------------------------------------------------------------------
   // Accumulator helpers
   // ---------------------------------------------------------------------------
   logic [CW-1:0] k_nxt;
   logic [PW-1:0] pc_cur;    // popcount of the beat being accepted
   logic [PW-1:0] pc_last;   // popcount of the final column (single bit)
   logic [PW-1:0] acc_nxt;

   assign k_nxt   = k_q + CW'(1);
   assign pc_cur  = PW'($countones(col_bits_q));
   assign pc_last = PW'($countones(col_tab[COLS-1]));
   assign acc_nxt = acc_q + (pc_cur << k_q);

   // ---------------------------------------------------------------------------
   // Next-state logic
   //
   // The output payload is registered one beat ahead: whenever a beat is
   // accepted, the next column is loaded into col_bits_q in the same edge. prod
   // is precomputed on the edge that enters the last beat, from the running
   // accumulator plus the last column's contribution, so no arithmetic sits
   // between the flops and the prod port.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      k_d        = k_q;
      acc_d      = acc_q;
      col_bits_d = col_bits_q;
      col_cnt_d  = col_cnt_q;
      out_last_d = out_last_q;
      prod_d     = prod_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d    = STREAM;
               a_d        = a;
               b_d        = b;
               k_d        = '0;
               acc_d      = '0;
               col_bits_d = col_tab[0];
               col_cnt_d  = cnt_tab[0];
               out_last_d = 1'b0;
               prod_d     = '0;
            end
         end

         STREAM: begin
            if (out_ready) begin
               if (k_q == K_LAST) begin
                  // Last beat taken: return to the cleared idle picture.
                  state_d    = IDLE;
                  k_d        = '0;
                  acc_d      = '0;
                  col_bits_d = '0;
                  col_cnt_d  = '0;
                  out_last_d = 1'b0;
                  prod_d     = '0;
               end else begin
                  k_d        = k_nxt;
                  acc_d      = acc_nxt;
                  col_bits_d = col_tab[k_nxt];
                  col_cnt_d  = cnt_tab[k_nxt];
                  out_last_d = (k_nxt == K_LAST);
                  prod_d     = (k_nxt == K_LAST)
                               ? (acc_nxt + (pc_last << (COLS-1)))
                               : '0;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         col_bits_q <= '0;
         col_cnt_q  <= '0;
         out_last_q <= 1'b0;
         prod_q     <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         k_q        <= k_d;
         acc_q      <= acc_d;
         col_bits_q <= col_bits_d;
         col_cnt_q  <= col_cnt_d;
         out_last_q <= out_last_d;
         prod_q     <= prod_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == STREAM);
   assign col_bits  = col_bits_q;
   assign col_cnt   = col_cnt_q;
   assign col_idx   = k_q;
   assign out_last  = out_last_q;
   assign prod      = prod_q;

endmodule

// File: tb/tb_pp_column_gen.sv
// -----------------------------------------------------------------------------
// tb_pp_column_gen
//
// Bench for pp_column_gen (N = 6). Every accepted operand pair expands, in a
// behavioural model, into its full list of expected column beats, which are
// queued in exp_q. A negedge compare process checks handshake signals and the
// head beat every cycle and pops it when the beat is taken. Directed cases log
// the beats the DUT delivered and pin them against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_pp_column_gen;

   localparam int N    = 6;
   localparam int COLS = 2*N-1;
   localparam int CW   = $clog2(COLS);
   localparam int PW   = 2*N;
   localparam int W    = N + 4 + CW + 1 + PW;

   // ---------------------------------------------------------------------------
   // DUT signals
   // ---------------------------------------------------------------------------
   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   col_bits;
   logic [3:0]     col_cnt;
   logic [CW-1:0]  col_idx;
   logic           out_last;
   logic [PW-1:0]  prod;

   pp_column_gen #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .col_bits  (col_bits),
      .col_cnt   (col_cnt),
      .col_idx   (col_idx),
      .out_last  (out_last),
      .prod      (prod)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_q[$];

   // Log of beats actually taken by the downstream side.
   logic [N-1:0]  log_bits [COLS];
   logic [3:0]    log_cnt  [COLS];
   int            log_beats;
   int            log_nz;
   int            log_lasts;
   int            log_last_idx;
   int            log_first_idx;
   logic [PW-1:0] log_prod;

   logic rdy_rand;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic clear_log();
      for (int k = 0; k < COLS; k++) begin
         log_bits[k] = '0;
         log_cnt[k]  = '0;
      end
      log_beats     = 0;
      log_nz        = 0;
      log_lasts     = 0;
      log_last_idx  = -1;
      log_first_idx = -1;
      log_prod      = '0;
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: expected beat k for operands av, bv
   // Packed as {col_bits, col_cnt, col_idx, out_last, prod}.
   // ---------------------------------------------------------------------------
   function automatic logic [W-1:0] model_beat(input int av, input int bv, input int k);
      int lo;
      int hi;
      int bits;
      int pr;
      lo   = (k - N + 1 > 0) ? (k - N + 1) : 0;
      hi   = (k < N - 1) ? k : (N - 1);
      bits = 0;
      for (int i = lo; i <= hi; i++) begin
         if ((((av >> (k - i)) & 1) == 1) && (((bv >> i) & 1) == 1))
            bits = bits | (1 << (i - lo));
      end
      pr = (k == COLS - 1) ? av * bv : 0;
      return {N'(bits), 4'(hi - lo + 1), CW'(k), (k == COLS - 1), PW'(pr)};
   endfunction

   // ---------------------------------------------------------------------------
   // Compare process (scoreboard)
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      logic [W-1:0] act;
      act = {col_bits, col_cnt, col_idx, out_last, prod};
      if (!rst_n) begin
         exp_q.delete();
         check("rst_in_ready", 64'(in_ready), 64'd1);
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_payload", 64'(act), 64'd0);
      end else begin
         check("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
         check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check("beat", 64'(act), 64'(exp_q[0]));
         end else begin
            check("idle_prod", 64'(prod), 64'd0);
            check("idle_last", 64'(out_last), 64'd0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (log_beats == 0) log_first_idx = int'(col_idx);
            log_bits[col_idx] = col_bits;
            log_cnt[col_idx]  = col_cnt;
            log_beats++;
            if (col_bits != '0) log_nz++;
            if (out_last) begin
               log_lasts++;
               log_last_idx = int'(col_idx);
               log_prod     = prod;
            end
         end
         if (in_valid && in_ready) begin
            for (int k = 0; k < COLS; k++)
               exp_q.push_back(model_beat(int'(a), int'(b), k));
         end
      end
   end

   // Random downstream backpressure when enabled.
   always @(posedge clk) begin
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (!in_ready && n < 400) begin
         // Junk requests while busy must be ignored.
         in_valid = 1'($urandom_range(0, 1));
         a        = N'($urandom);
         b        = N'($urandom);
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = N'($urandom);
      b        = N'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!in_ready && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("done_timeout", 64'd0, 64'd1);
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #1000000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int n;
      int s4;
      int s10;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      rdy_rand  = 1'b0;
      clear_log();

      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_col_idx", 64'(col_idx), 64'd0);
      check("reset_prod", 64'(prod), 64'd0);
      #2 rst_n = 1'b1;

      // Full ones: 63 x 63.
      out_ready = 1'b1;
      clear_log();
      send(6'd63, 6'd63);
      n = 1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("ones_ready_cycle", 64'(n), 64'd12);
      check("ones_beats", 64'(log_beats), 64'd11);
      check("ones_prod", 64'(log_prod), 64'd3969);
      check("ones_lasts", 64'(log_lasts), 64'd1);
      check("ones_last_idx", 64'(log_last_idx), 64'd10);
      check("ones_bits_k5", 64'(log_bits[5]), 64'b111111);
      check("ones_bits_k0", 64'(log_bits[0]), 64'b000001);
      check("ones_bits_k9", 64'(log_bits[9]), 64'b000011);
      check("ones_cnt_k3", 64'(log_cnt[3]), 64'd4);
      check("ones_cnt_k5", 64'(log_cnt[5]), 64'd6);
      check("ones_cnt_k8", 64'(log_cnt[8]), 64'd3);

      // Single bit: 1 x 32.
      clear_log();
      send(6'd1, 6'd32);
      wait_done();
      check("single_bits_k5", 64'(log_bits[5]), 64'b100000);
      check("single_nonzero", 64'(log_nz), 64'd1);
      check("single_prod", 64'(log_prod), 64'd32);

      // Zero operand: 0 x 45.
      clear_log();
      send(6'd0, 6'd45);
      wait_done();
      check("zero_nonzero", 64'(log_nz), 64'd0);
      check("zero_cnt_k5", 64'(log_cnt[5]), 64'd6);
      check("zero_cnt_k10", 64'(log_cnt[10]), 64'd1);
      check("zero_prod", 64'(log_prod), 64'd0);
      check("zero_lasts", 64'(log_lasts), 64'd1);

      // Backpressure: 21 x 42, stalls at k=4 (3 cycles) and k=10 (2 cycles).
      clear_log();
      send(6'd21, 6'd42);
      s4  = 0;
      s10 = 0;
      n   = 0;
      while (!in_ready && n < 100) begin
         if (out_valid && col_idx == CW'(4) && s4 < 3) begin
            out_ready = 1'b0;
            s4++;
         end else if (out_valid && col_idx == CW'(10) && s10 < 2) begin
            out_ready = 1'b0;
            s10++;
         end else begin
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b1;
      check("bp_stalls", 64'(s4 + s10), 64'd5);
      check("bp_beats", 64'(log_beats), 64'd11);
      check("bp_prod", 64'(log_prod), 64'd882);

      // Ignored input: 7 x 7 pulsed during the 3 x 5 stream.
      clear_log();
      send(6'd3, 6'd5);
      repeat (3) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      a        = 6'd7;
      b        = 6'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done();
      check("ign_beats", 64'(log_beats), 64'd11);
      check("ign_prod", 64'(log_prod), 64'd15);
      clear_log();
      send(6'd7, 6'd7);
      wait_done();
      check("ign_next_prod", 64'(log_prod), 64'd49);

      // Reset mid-stream at k=6.
      send(6'd9, 6'd11);
      n = 0;
      while (!(out_valid && col_idx == CW'(6)) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_reach_k6", 64'(col_idx), 64'd6);
      #2 rst_n = 1'b0;
      #1;
      check("mid_out_valid", 64'(out_valid), 64'd0);
      check("mid_in_ready", 64'(in_ready), 64'd1);
      check("mid_col_bits", 64'(col_bits), 64'd0);
      check("mid_col_idx", 64'(col_idx), 64'd0);
      check("mid_prod", 64'(prod), 64'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      clear_log();
      send(6'd2, 6'd3);
      wait_done();
      check("post_first_idx", 64'(log_first_idx), 64'd0);
      check("post_beats", 64'(log_beats), 64'd11);
      check("post_prod", 64'(log_prod), 64'd6);

      // Randomised traffic with random backpressure.
      rdy_rand = 1'b1;
      for (int t = 0; t < 40; t++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(N'($urandom), N'($urandom));
      end
      wait_done();
      rdy_rand  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pp_column_gen.md
Name: pp_column_gen

Overview:
- Sequential partial-product generator. It is the producer side of the approximate compressor tree.
- Accepts one N x N unsigned operand pair per transaction and streams the AND-array partial products one weight column per beat, using a valid/ready handshake, to a downstream column-compressor stage.
- Also accumulates and reports the exact product on the last beat. The bench uses this value as the golden reference when measuring approximate-multiplier error.

Parameters:
- N, 6, operand width; legal range 2..8.
- COLS, 2*N-1, number of weight columns (derived; do not override).
- CW, clog2(COLS), width of col_idx (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- out_valid  out  1  column beat valid.
- out_ready  in  1  downstream accepts beat.
- col_bits  out  N  packed partial-product bits of the current column.
- col_cnt  out  4  number of valid bits in col_bits (column height).
- col_idx  out  CW  column weight k.
- out_last  out  1  high on the final column beat (k = COLS-1).
- prod  out  2N  exact product a*b; meaningful only when out_valid & out_last, 0 otherwise.

Behaviour:
- Reset values (asynchronous assert, synchronous deassert to clk):
  - FSM = IDLE.
  - in_ready = 1 after reset.
  - out_valid = 0, col_bits = 0, col_cnt = 0, col_idx = 0, out_last = 0, prod = 0.
  - Internal operand registers, column counter and accumulator cleared.
- Partial product: pp[i][j] = a[j] & b[i], weight k = i + j, for i, j in 0..N-1.
- Column k packing:
  - lo = max(0, k-N+1), hi = min(k, N-1).
  - Bit position p = i - lo holds pp[i][k-i] for i = lo..hi.
  - Bits above col_cnt-1 are 0.
  - col_cnt = hi - lo + 1 (1,2,...,N,...,2,1).
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0. On in_valid & in_ready, register a and b, set k = 0, clear the accumulator, go to STREAM.
  - STREAM: in_ready = 0, out_valid = 1. Outputs come from registers and describe column k.
    - On out_ready and k < COLS-1: accumulator += popcount(col_bits) << k, then k++.
    - On out_ready and k = COLS-1: go to IDLE.
- Latency: first beat is visible the cycle after acceptance. With out_ready held high, a transaction is COLS consecutive beats. in_ready reasserts the cycle after the last beat is accepted.
- Minimum spacing between transactions is COLS+1 cycles. There is no back-to-back overlap.
- Backpressure: while out_valid & !out_ready, all outputs are held stable. The beat is never dropped or repeated.
- prod = accumulator + (popcount(col_bits) << (COLS-1)), driven only on the last beat. Width is 2N with no overflow, since the maximum is (2^N-1)^2.
- in_valid while in STREAM is ignored. a and b changing after acceptance have no effect.
- out_ready while in IDLE is ignored.
- rst_n asserted mid-stream: outputs go to reset values immediately. The partial transaction is discarded with no last beat.
- No combinational path from in_valid or out_ready to any output except through state registers. in_ready and out_valid are decoded from the registered state only.

Test Plan:
- Full ones, N=6: a=63, b=63, out_ready=1.
  - Required: 11 beats, k=0..10.
  - col_cnt 1,2,3,4,5,6,5,4,3,2,1.
  - Each col_bits has all valid bits set (e.g. k=5 -> 6'b111111).
  - out_last only at k=10, prod=3969.
  - in_ready high again on cycle 12 after acceptance.
- Single bit: a=1, b=32.
  - Required: only k=5 is nonzero, col_bits=6'b100000 (i=5 at p=5).
  - All other columns are 0, prod=32.
- Zero operand: a=0, b=45 -> all col_bits=0 with col_cnt still 1..6..1, prod=0 on the last beat.
- Backpressure: a=21, b=42, out_ready low for 3 cycles at k=4 and low again at k=10.
  - Required: outputs frozen during the stalls, no skipped or duplicated k.
  - prod=882 once accepted.
- Ignored input: in_valid pulsed with a=7, b=7 during STREAM of a=3, b=5.
  - Required: the stream continues for 3x5, prod=15.
  - The new pair is accepted only after in_ready returns.
- Reset mid-stream: deassert-then-assert rst_n at k=6.
  - Required: out_valid=0 and in_ready=1 immediately (asynchronous).
  - The next transaction a=2, b=3 streams from k=0 with prod=6.
